// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared sizes, scanner states and row-drive helper for the keypad scanner
package keypad_pkg;

  localparam int NUM_ROWS = 5;
  localparam int NUM_COLS = 4;
  localparam int CODE_W   = 5;

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    CONFIRM = 2'd1,
    HELD    = 2'd2
  } kp_state_e;

  // Row drive with only the selected row pulled low.
  function automatic logic [NUM_ROWS-1:0] onehot_low(input logic [2:0] row_idx);
    return ~(NUM_ROWS'(1) << row_idx);
  endfunction

endpackage

// File: rtl/kp_col_sync.sv
// rtl/kp_col_sync.sv - two-flop synchronizer for the asynchronous column inputs, resets to all-ones
module kp_col_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] meta;

  // Two-stage capture; idle columns read high, so reset matches "no key".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '1;
      dout <= '1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// rtl/keypad_matrix_scanner.sv - 5x4 matrix scanner with debounce; optional auto-repeat under KEYPAD_AUTOREPEAT_EN
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int ROW_DWELL    = 50000,
  parameter int DEB_CYCLES   = 100000
`ifdef KEYPAD_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY = 50000000,
  parameter int REPEAT_RATE  = 10000000
`endif
) (
  input  logic              clk,
  input  logic              RSTN,
  input  logic [3:0]        K_COL,
  output logic [4:0]        K_ROW,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_pulse,
  output logic              key_release
);

  localparam int CNT_MAX = (ROW_DWELL > DEB_CYCLES) ? ROW_DWELL : DEB_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(ROW_DWELL - 1);
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);

  logic [NUM_COLS-1:0] col_s;
  kp_state_e           state;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_inc;
  logic [2:0]          row_idx;
  logic [2:0]          row_next;
  logic [CODE_W-1:0]   cand_code;
  logic [NUM_COLS-1:0] cand_pat;
  logic                one_low;
  logic [1:0]          low_idx;
  logic                rep_fire;

  kp_col_sync #(.W(NUM_COLS)) u_col_sync (
    .clk   (clk),
    .rst_n (RSTN),
    .din   (K_COL),
    .dout  (col_s)
  );

  assign row_next = (row_idx == 3'(NUM_ROWS - 1)) ? 3'd0 : row_idx + 3'd1;
  assign cnt_inc  = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

  // Classify the sampled columns: a single low bit is a candidate key, anything else is idle or ghosting.
  always_comb begin
    one_low = ($countones(~col_s) == 1);
    low_idx = 2'd0;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (!col_s[c]) low_idx = 2'(c);
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
  localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE - 1);

  logic [REP_W-1:0] rep_cnt;
  logic             rep_first;
  logic             key_down;

  assign key_down = (col_s != '1);
  assign rep_fire = (state == HELD) && key_down &&
                    (rep_first ? (rep_cnt == RATE_LAST) : (rep_cnt == DELAY_LAST));

  // Repeat timer: long initial delay, then the shorter rate; any all-high sample restarts it.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      rep_cnt   <= '0;
      rep_first <= 1'b0;
    end else if (state != HELD || !key_down) begin
      rep_cnt   <= '0;
      rep_first <= 1'b0;
    end else if (rep_fire) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (rep_cnt != {REP_W{1'b1}}) begin
      rep_cnt <= rep_cnt + REP_W'(1);
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Scan/confirm/held sequencer; the row stays frozen outside SCAN so the candidate key remains visible.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state       <= SCAN;
      cnt         <= '0;
      row_idx     <= 3'd0;
      K_ROW       <= 5'b11110;
      cand_code   <= '0;
      cand_pat    <= '1;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_pulse   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_pulse   <= 1'b0;
      key_release <= 1'b0;
      case (state)
        SCAN: begin
          if (cnt == DWELL_LAST) begin
            cnt <= '0;
            if (one_low) begin
              cand_code <= {row_idx, low_idx};
              cand_pat  <= col_s;
              state     <= CONFIRM;
            end else begin
              row_idx <= row_next;
              K_ROW   <= onehot_low(row_next);
            end
          end else begin
            cnt <= cnt_inc;
          end
        end
        CONFIRM: begin
          if (col_s != cand_pat) begin
            cnt     <= '0;
            row_idx <= row_next;
            K_ROW   <= onehot_low(row_next);
            state   <= SCAN;
          end else if (cnt == DEB_LAST) begin
            key_code  <= cand_code;
            key_valid <= 1'b1;
            key_pulse <= 1'b1;
            cnt       <= '0;
            state     <= HELD;
          end else begin
            cnt <= cnt_inc;
          end
        end
        HELD: begin
          if (rep_fire) key_pulse <= 1'b1;
          if (col_s != '1) begin
            cnt <= '0;
          end else if (cnt == DEB_LAST) begin
            key_valid   <= 1'b0;
            key_release <= 1'b1;
            cnt         <= '0;
            row_idx     <= row_next;
            K_ROW       <= onehot_low(row_next);
            state       <= SCAN;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          cnt   <= '0;
          state <= SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb/tb_keypad_matrix_scanner.sv - randomized self-checking bench for keypad_matrix_scanner
module tb_keypad_matrix_scanner;

  localparam int ROW_DWELL  = 8;
  localparam int DEB_CYCLES = 16;
  localparam int LAT_MAX    = ROW_DWELL * 5 + DEB_CYCLES + 6;

  logic       clk = 1'b0;
  logic       RSTN = 1'b0;
  logic [3:0] K_COL;
  logic [4:0] K_ROW;
  logic [4:0] key_code;
  logic       key_valid;
  logic       key_pulse;
  logic       key_release;

  logic [19:0] keys = '0;
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int pulse_cnt = 0;
  int rel_cnt   = 0;
  int both_cnt  = 0;
  int pulse_times[$];

  keypad_matrix_scanner #(
    .ROW_DWELL  (ROW_DWELL),
    .DEB_CYCLES (DEB_CYCLES)
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY (100),
    .REPEAT_RATE  (40)
`endif
  ) dut (
    .clk         (clk),
    .RSTN        (RSTN),
    .K_COL       (K_COL),
    .K_ROW       (K_ROW),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_pulse   (key_pulse),
    .key_release (key_release)
  );

  always #5 clk = ~clk;

  // Passive matrix: a pressed key shorts its column to its row when that row is driven low.
  always_comb begin
    K_COL = 4'hF;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !K_ROW[r]) K_COL[c] = 1'b0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (key_pulse) begin
      pulse_cnt <= pulse_cnt + 1;
      pulse_times.push_back(cyc);
    end
    if (key_release) rel_cnt <= rel_cnt + 1;
    if (key_pulse && key_release) both_cnt <= both_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [4:0] row_drive(input int r);
    logic [4:0] one;
    one = 5'd1;
    return ~(one << r);
  endfunction

  // Extra pulses expected when the key stays down for d cycles after the confirm pulse.
  function automatic int exp_repeats(input int d);
    int n;
    n = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
    for (int k = 100; k <= d + 2; k += 40) n++;
`else
    if (d < 0) n = 0;
`endif
    return n;
  endfunction

  task automatic wait_row_change(output int n);
    logic [4:0] prev;
    prev = K_ROW;
    n = 0;
    do begin
      tick();
      n++;
    end while (K_ROW == prev && n < 40);
  endtask

  task automatic press_cycle(input int r, input int c, input int bn, input int bp,
                             input int hold, input string tag);
    int idx, p0, r0, n, bad, found;
    idx = r * 4 + c;
    p0 = pulse_cnt;
    r0 = rel_cnt;
    for (int i = 0; i < bn; i++) begin
      keys[idx] = (i % 2 == 0);
      repeat (bp) tick();
    end
    check_eq({tag, "_bounce_quiet"}, pulse_cnt - p0, 0);
    keys[idx] = 1'b1;
    found = 0;
    n = 0;
    while (!found && n < LAT_MAX) begin
      tick();
      n++;
      if (key_pulse) found = 1;
    end
    check_eq({tag, "_pulse_seen"}, found, 1);
    check_eq({tag, "_code"}, int'(key_code), idx);
    check_eq({tag, "_valid"}, int'(key_valid), 1);
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (K_ROW != row_drive(r)) bad++;
    end
    check_eq({tag, "_row_frozen"}, bad, 0);
    keys[idx] = 1'b0;
    found = 0;
    n = 0;
    while (!found && n < 30) begin
      tick();
      n++;
      if (key_release) found = 1;
    end
    check_eq({tag, "_release_seen"}, found, 1);
    check_eq({tag, "_release_lat"}, n, (n >= 16 && n <= 19) ? n : 18);
    check_eq({tag, "_valid_low"}, int'(key_valid), 0);
    check_eq({tag, "_code_kept"}, int'(key_code), idx);
    check_eq({tag, "_row_resume"}, int'(K_ROW), int'(row_drive((r + 1) % 5)));
    check_eq({tag, "_pulses"}, pulse_cnt - p0, 1 + exp_repeats(hold));
    check_eq({tag, "_releases"}, rel_cnt - r0, 1);
    repeat (3) tick();
  endtask

  task automatic ghost(input int r, input int c1, input int c2, input string tag);
    int p0, n, changes;
    logic [4:0] prev;
    p0 = pulse_cnt;
    keys[r*4+c1] = 1'b1;
    keys[r*4+c2] = 1'b1;
    changes = 0;
    prev = K_ROW;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (K_ROW != prev) changes++;
      prev = K_ROW;
    end
    n = (changes >= 12) ? 1 : 0;
    check_eq({tag, "_rotating"}, n, 1);
    check_eq({tag, "_no_pulse"}, pulse_cnt - p0, 0);
    keys = '0;
    repeat (4) tick();
  endtask

  initial begin
    int n, r, c, c2, found, r0, t0;
    RSTN = 1'b0;
    repeat (3) @(posedge clk);
    tick();
    check_eq("rst_row", int'(K_ROW), 5'b11110);
    check_eq("rst_code", int'(key_code), 0);
    check_eq("rst_valid", int'(key_valid), 0);
    check_eq("rst_pulse", int'(key_pulse), 0);
    check_eq("rst_release", int'(key_release), 0);
    RSTN = 1'b1;

    for (int k = 1; k <= 5; k++) begin
      wait_row_change(n);
      check_eq($sformatf("idle_dwell_%0d", k), n, ROW_DWELL);
      check_eq($sformatf("idle_row_%0d", k), int'(K_ROW), int'(row_drive(k % 5)));
    end
    check_eq("idle_no_pulse", pulse_cnt, 0);
    check_eq("idle_no_release", rel_cnt, 0);
    check_eq("idle_valid", int'(key_valid), 0);

    press_cycle(3, 2, 0, 1, 150, "clean");
    press_cycle(3, 2, 12, 5, 60, "bouncy");
    ghost(1, 1, 3, "ghost");

    for (int i = 0; i < 6; i++) begin
      r = $urandom_range(0, 4);
      c = $urandom_range(0, 3);
      repeat ($urandom_range(0, 20)) tick();
      press_cycle(r, c, $urandom_range(0, 6), $urandom_range(1, 5),
                  $urandom_range(20, 90), $sformatf("rand%0d", i));
    end

    r = $urandom_range(0, 4);
    c = $urandom_range(0, 3);
    c2 = (c + $urandom_range(1, 3)) % 4;
    ghost(r, c, c2, "rghost");

    r = $urandom_range(0, 4);
    c = $urandom_range(0, 3);
    r0 = rel_cnt;
    keys[r*4+c] = 1'b1;
    found = 0;
    n = 0;
    while (!found && n < LAT_MAX) begin
      tick();
      n++;
      if (key_pulse) found = 1;
    end
    check_eq("midrst_pulse_seen", found, 1);
    repeat (10) tick();
    RSTN = 1'b0;
    tick();
    check_eq("midrst_valid", int'(key_valid), 0);
    check_eq("midrst_code", int'(key_code), 0);
    check_eq("midrst_row", int'(K_ROW), 5'b11110);
    keys = '0;
    repeat (3) tick();
    RSTN = 1'b1;
    repeat (40) tick();
    check_eq("midrst_no_release", rel_cnt - r0, 0);
    check_eq("midrst_valid_after", int'(key_valid), 0);

`ifdef KEYPAD_AUTOREPEAT_EN
    pulse_times.delete();
    keys[0] = 1'b1;
    found = 0;
    n = 0;
    while (!found && n < LAT_MAX) begin
      tick();
      n++;
      if (key_pulse) found = 1;
    end
    check_eq("rep_first_seen", found, 1);
    repeat (280) tick();
    keys[0] = 1'b0;
    repeat (30) tick();
    check_eq("rep_count", pulse_times.size(), 6);
    if (pulse_times.size() == 6) begin
      t0 = pulse_times[0];
      check_eq("rep_off1", pulse_times[1] - t0, 100);
      check_eq("rep_off2", pulse_times[2] - t0, 140);
      check_eq("rep_off3", pulse_times[3] - t0, 180);
      check_eq("rep_off4", pulse_times[4] - t0, 220);
      check_eq("rep_off5", pulse_times[5] - t0, 260);
    end
`else
    t0 = 0;
`endif

    check_eq("pulse_release_exclusive", both_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
